// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. It synchronises rx_data, deframes characters LSB first,
// and presents each byte on a one-entry AXI-Stream output register.
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 25_000_000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_data,
    output logic [7:0] axis_tdata,
    output logic       axis_tvalid,
    input  logic       axis_tready,
    output logic       frame_error,
    output logic       overrun
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         idx_q;
    logic [7:0]         shift_q;
    logic [7:0]         tdata_q;
    logic               tvalid_q;
    logic               fe_q;
    logic               ovr_q;
    logic               rx_meta_q;
    logic               rx_s_q;

    // Two-flop synchroniser. It resets to the idle level so that releasing reset cannot fake a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_data;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Deframing FSM with the output register. Error pulses default low each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            fe_q     <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            fe_q  <= 1'b0;
            ovr_q <= 1'b0;
            if (tvalid_q && axis_tready) begin
                tvalid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                        cnt_q <= '0;
                        if (!rx_s_q) begin
                            idx_q   <= '0;
                            state_q <= ST_DATA;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_s_q;
                        if (idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            state_q <= ST_IDLE;
                            // A byte accepted on this same edge frees the slot for the new byte.
                            if (!tvalid_q || axis_tready) begin
                                tdata_q  <= shift_q;
                                tvalid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                        end else begin
                            fe_q    <= 1'b1;
                            state_q <= ST_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    if (rx_s_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign axis_tdata  = tdata_q;
    assign axis_tvalid = tvalid_q;
    assign frame_error = fe_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: the bench drives serial frames into uart_rx and checks the AXI-Stream output
// and the error pulses against expected byte streams.
module tb_uart_rx;

    localparam int unsigned CLK_FREQ  = 1_700_000;
    localparam int unsigned BAUD_RATE = 100_000;
    localparam int unsigned CPB       = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF      = CPB / 2;
    localparam int          LAT       = int'(HALF + 9 * CPB + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_data = 1'b1;
    logic       axis_tready = 1'b0;
    logic [7:0] axis_tdata;
    logic       axis_tvalid;
    logic       frame_error;
    logic       overrun;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .axis_tdata  (axis_tdata),
        .axis_tvalid (axis_tvalid),
        .axis_tready (axis_tready),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor. It samples between edges and records transfers and pulses.
    logic [7:0] xfer_q[$];
    int   fe_cnt = 0, ovr_cnt = 0, both_cnt = 0, unstable_cnt = 0;
    int   rise_cnt = 0, fall_cnt = 0, rise_cyc = 0;
    logic prev_valid = 1'b0, prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always begin
        @(negedge clk);
        #2;
        if (frame_error) fe_cnt++;
        if (overrun) ovr_cnt++;
        if (frame_error && overrun) both_cnt++;
        if (axis_tvalid && axis_tready) xfer_q.push_back(axis_tdata);
        if (prev_hold && rst_n && (!axis_tvalid || axis_tdata != prev_data)) unstable_cnt++;
        if (axis_tvalid && !prev_valid) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        if (!axis_tvalid && prev_valid) fall_cnt++;
        prev_valid = axis_tvalid;
        prev_hold  = axis_tvalid && !axis_tready && rst_n;
        prev_data  = axis_tdata;
    end

    // Serial transmitter model. It is entered at a negedge and leaves at a negedge, so frames chain with no gap.
    int start_cyc = 0;
    task automatic send_byte(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        rx_data = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_data = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_data = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_data = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    function automatic int xfer_at(input int i);
        if (i < xfer_q.size()) return int'(xfer_q[i]);
        return -1;
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_xfers;
        int         exp_fe;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int x0, fe0, ovr0, r0, f0, d;
        logic [7:0] exp_q[$];
        logic done;

        vecs[0] = '{8'h61, 1'b1, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 0};
        vecs[3] = '{8'hA5, 1'b1, 1, 0};
        vecs[4] = '{8'h80, 1'b1, 1, 0};
        vecs[5] = '{8'h01, 1'b1, 1, 0};
        vecs[6] = '{8'h3C, 1'b0, 0, 1};

        // Check the outputs while reset is held.
        repeat (3) @(negedge clk);
        check("reset_tvalid", int'(axis_tvalid), 0);
        check("reset_tdata", int'(axis_tdata), 0);
        check("reset_frame_error", int'(frame_error), 0);
        check("reset_overrun", int'(overrun), 0);
        rst_n = 1'b1;
        idle(2 * CPB);

        // Table of single frames with the sink always ready.
        axis_tready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            x0 = xfer_q.size(); fe0 = fe_cnt; ovr0 = ovr_cnt; r0 = rise_cnt;
            send_byte(vecs[i].data, vecs[i].stop);
            idle(2 * CPB);
            check($sformatf("vec%0d_xfers", i), xfer_q.size() - x0, vecs[i].exp_xfers);
            check($sformatf("vec%0d_valid_pulses", i), rise_cnt - r0, vecs[i].exp_xfers);
            check($sformatf("vec%0d_frame_error", i), fe_cnt - fe0, vecs[i].exp_fe);
            check($sformatf("vec%0d_overrun", i), ovr_cnt - ovr0, 0);
            if (vecs[i].exp_xfers == 1) begin
                check($sformatf("vec%0d_data", i), xfer_at(x0), int'(vecs[i].data));
                d = rise_cyc - start_cyc;
                check($sformatf("vec%0d_latency_%0d_in_window", i, d),
                      int'(d >= LAT - 3 && d <= LAT + 3), 1);
            end
        end

        // Backpressure: the second byte is dropped and the first is held.
        axis_tready = 1'b0;
        x0 = xfer_q.size(); ovr0 = ovr_cnt; fe0 = fe_cnt;
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        idle(2 * CPB);
        check("bp_overrun_pulses", ovr_cnt - ovr0, 1);
        check("bp_no_xfer", xfer_q.size() - x0, 0);
        check("bp_tvalid_held", int'(axis_tvalid), 1);
        check("bp_tdata_held", int'(axis_tdata), 8'h55);
        check("bp_frame_error", fe_cnt - fe0, 0);
        axis_tready = 1'b1;
        idle(4);
        check("bp_drain_count", xfer_q.size() - x0, 1);
        check("bp_drain_data", xfer_at(x0), 8'h55);
        check("bp_drain_tvalid_low", int'(axis_tvalid), 0);

        // An accept and a commit land on the same edge.
        axis_tready = 1'b0;
        send_byte(8'h55, 1'b1);
        idle(CPB);
        x0 = xfer_q.size(); ovr0 = ovr_cnt; f0 = fall_cnt;
        fork
            send_byte(8'h3C, 1'b1);
            begin
                @(negedge clk);
                for (int k = 0; k < 20 * int'(CPB) && cyc != start_cyc + int'(HALF + 9 * CPB) + 2; k++)
                    @(negedge clk);
                axis_tready = 1'b1;
                @(negedge clk);
                axis_tready = 1'b0;
            end
        join
        idle(2);
        check("sim_xfer_count", xfer_q.size() - x0, 1);
        check("sim_xfer_data", xfer_at(x0), 8'h55);
        check("sim_no_overrun", ovr_cnt - ovr0, 0);
        check("sim_tvalid_continuous", fall_cnt - f0, 0);
        check("sim_tvalid_new", int'(axis_tvalid), 1);
        check("sim_tdata_new", int'(axis_tdata), 8'h3C);
        axis_tready = 1'b1;
        idle(3);
        check("sim_drain_data", xfer_at(x0 + 1), 8'h3C);

        // Bad stop bit followed by a held-low line, then a good frame.
        x0 = xfer_q.size(); fe0 = fe_cnt; ovr0 = ovr_cnt;
        send_byte(8'hF0, 1'b0);
        rx_data = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        idle(2 * CPB);
        send_byte(8'h12, 1'b1);
        idle(2 * CPB);
        check("frm_error_pulses", fe_cnt - fe0, 1);
        check("frm_xfer_count", xfer_q.size() - x0, 1);
        check("frm_xfer_data", xfer_at(x0), 8'h12);
        check("frm_overrun", ovr_cnt - ovr0, 0);

        // A short low glitch must be ignored.
        x0 = xfer_q.size(); fe0 = fe_cnt; r0 = rise_cnt;
        rx_data = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        idle(3 * CPB);
        check("glitch_no_xfer", xfer_q.size() - x0, 0);
        check("glitch_no_valid", rise_cnt - r0, 0);
        check("glitch_no_frame_error", fe_cnt - fe0, 0);

        // Reset mid-frame while a byte is pending.
        axis_tready = 1'b0;
        send_byte(8'h77, 1'b1);
        idle(CPB);
        check("rst_pending_before", int'(axis_tvalid), 1);
        x0 = xfer_q.size(); fe0 = fe_cnt; ovr0 = ovr_cnt;
        fork
            send_byte(8'h81, 1'b1);
            begin
                repeat (HALF + 4 * CPB) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                check("rst_mid_tvalid", int'(axis_tvalid), 0);
                check("rst_mid_tdata", int'(axis_tdata), 0);
                check("rst_mid_frame_error", int'(frame_error), 0);
                check("rst_mid_overrun", int'(overrun), 0);
            end
        join
        idle(CPB);
        rst_n = 1'b1;
        axis_tready = 1'b1;
        idle(2 * CPB);
        check("rst_no_xfer", xfer_q.size() - x0, 0);
        check("rst_no_frame_error", fe_cnt - fe0, 0);
        send_byte(8'h81, 1'b1);
        idle(2 * CPB);
        check("rst_after_count", xfer_q.size() - x0, 1);
        check("rst_after_data", xfer_at(x0), 8'h81);

        // Random bytes with random sink readiness, compared against the sent-byte queue.
        x0 = xfer_q.size(); fe0 = fe_cnt; ovr0 = ovr_cnt;
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 256; n++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    exp_q.push_back(b);
                    send_byte(b, 1'b1);
                    idle(int'($urandom_range(0, 3)));
                end
                idle(2 * CPB);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    axis_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        axis_tready = 1'b1;
        idle(4);
        check("loop_count", xfer_q.size() - x0, exp_q.size());
        for (int n = 0; n < exp_q.size(); n++)
            check($sformatf("loop_byte%0d", n), xfer_at(x0 + n), int'(exp_q[n]));
        check("loop_frame_error", fe_cnt - fe0, 0);
        check("loop_overrun", ovr_cnt - ovr0, 0);

        check("never_both_pulses", both_cnt, 0);
        check("held_data_stable", unstable_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
